// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with carry/borrow, signed overflow and zero flags.
// Latency: STAGES rising edges from operand capture to out_valid; one result per cycle.
// Backpressure: single global stall; in_ready = ~out_valid | out_ready and every stage holds while stalled.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, c_in, sub)
//   a, b                WIDTH-bit operands
//   c_in                carry-in for add, borrow-in for subtract
//   sub                 0 = a + b + c_in, 1 = a - b - c_in
//   out_valid/out_ready result handshake
//   sum                 WIDTH-bit result
//   c_out               carry out of the MSB (for subtract: 1 = no borrow)
//   overflow            two's-complement signed overflow
//   zero                sum == 0
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW    = WIDTH / STAGES;
    // Stages 0..STAGES-2 live in pipe_q; the last stage is the output register
    // set itself. Keep the array non-empty for the single-stage build.
    localparam int NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

    // One in-flight operation between stages. The remaining operand fields are
    // shifted down each stage so the chunk to work on is always in [CW-1:0];
    // sum holds the finished low chunks with zeros above them.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic             cy;
    } stg_t;

    stg_t src    [STAGES];   // what stage k works on this cycle
    stg_t nxt    [STAGES];   // stage k result, captured on advance
    stg_t pipe_q [NPIPE];

    logic adv;
    logic ovf_last;
    logic zero_last;

    // Global advance: the whole pipe moves unless a valid result is waiting
    // on a consumer that is not ready. Bubbles move with the pipe.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        logic [CW:0] chunk;

        // Stage 0 takes the raw operands; subtract is a + ~b + 1 with the
        // borrow-in folded into the inverted carry-in.
        src[0].vld = in_valid;
        src[0].sum = '0;
        src[0].a   = a;
        src[0].bx  = sub ? ~b : b;
        src[0].cy  = c_in ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = pipe_q[k-1];
        end

        chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk      = {1'b0, src[k].a[CW-1:0]} + {1'b0, src[k].bx[CW-1:0]}
                       + {{CW{1'b0}}, src[k].cy};
            nxt[k]     = src[k];
            nxt[k].sum = src[k].sum | (WIDTH'(chunk[CW-1:0]) << (k * CW));
            nxt[k].a   = src[k].a >> CW;
            nxt[k].bx  = src[k].bx >> CW;
            nxt[k].cy  = chunk[CW];
        end

        // In the last stage the working chunk is the top chunk, so bit CW-1 of
        // the remaining operands is the operand sign bit.
        ovf_last  = (src[STAGES-1].a[CW-1] == src[STAGES-1].bx[CW-1])
                 && (nxt[STAGES-1].sum[WIDTH-1] != src[STAGES-1].a[CW-1]);
        zero_last = ~|nxt[STAGES-1].sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPIPE; k++) begin
                pipe_q[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                pipe_q[k] <= nxt[k];
            end
            out_valid <= nxt[STAGES-1].vld;
            // Result registers only load real results, so the last result
            // stays visible while a bubble sits at the output.
            if (nxt[STAGES-1].vld) begin
                sum      <= nxt[STAGES-1].sum;
                c_out    <= nxt[STAGES-1].cy;
                overflow <= ovf_last;
                zero     <= zero_last;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations (32/2, 32/1, 16/4) run in parallel.
// Each configuration has its own driver, expected-result queue and output monitor.
// The monitor pops and compares on every output handshake and checks hold-stability while stalled.
`timescale 1ns/1ps
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done [3];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = (g == 2) ? 16 : 32;
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        localparam logic [W-1:0] ONES  = '1;
        localparam logic [W-1:0] MAXP  = ONES >> 1;
        localparam logic [W-1:0] MINN  = ~MAXP;
        localparam logic [W-1:0] BIT_H = W'(1) << (W / 2);
        localparam logic [W-1:0] HALF  = BIT_H - W'(1);

        typedef struct packed {
            logic [W-1:0] s;
            logic         c;
            logic         v;
            logic         z;
        } exp_t;

        logic         rst_n     = 1'b1;
        logic         out_ready = 1'b1;
        logic         in_valid, in_ready, c_in, sub, out_valid, c_out, overflow, zero;
        logic [W-1:0] a, b, sum;
        exp_t         exp_q [$];
        bit           rand_or  = 1'b0;
        bit           or_force = 1'b1;
        string        tag;

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .c_in      (c_in),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .c_out     (c_out),
            .overflow  (overflow),
            .zero      (zero)
        );

        // Consumer: fixed or 50% random ready, changed 2 ns after each edge.
        initial forever begin
            @(posedge clk);
            #2;
            out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_force;
        end

        // Monitor: compare on handshake, check hold while stalled.
        initial begin
            bit   stall_q = 1'b0;
            exp_t last_q  = '0;
            exp_t got, e;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    stall_q = 1'b0;
                end else begin
                    got.s = sum;
                    got.c = c_out;
                    got.v = overflow;
                    got.z = zero;
                    if (stall_q) begin
                        chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
                        chk({tag, "_hold_data"}, 64'(got), 64'(last_q));
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk({tag, "_unexpected_out"}, 64'(out_valid), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk({tag, "_result"}, 64'(got), 64'(e));
                        end
                    end
                    stall_q = out_valid && !out_ready;
                    last_q  = got;
                end
            end
        end

        function automatic exp_t mk(input logic [W-1:0] s, input logic c, v, z);
            exp_t e;
            e.s = s;
            e.c = c;
            e.v = v;
            e.z = z;
            return e;
        endfunction

        // Flat reference: a +/- b with carry, straight from the operation definition.
        function automatic exp_t model(input logic [W-1:0] ta, tb_, input logic tc, ts);
            logic [W-1:0] bx;
            logic [W:0]   r;
            bx = ts ? ~tb_ : tb_;
            r  = {1'b0, ta} + {1'b0, bx} + (W + 1)'(tc ^ ts);
            return mk(r[W-1:0], r[W], (ta[W-1] == bx[W-1]) && (r[W-1] != ta[W-1]),
                      r[W-1:0] == '0);
        endfunction

        // Present one operation; push its expected result once accepted.
        // Returns 1 ns after the capture edge with in_valid low.
        task automatic send(input logic [W-1:0] ta, tb_, input logic tc, ts, input exp_t e);
            int  t = 0;
            bit  ok = 1'b0;
            a        = ta;
            b        = tb_;
            c_in     = tc;
            sub      = ts;
            in_valid = 1'b1;
            while (!ok && t < 200) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                else          t++;
            end
            if (ok) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
            end else begin
                chk({tag, "_send_timeout"}, 64'(in_ready), 64'(1));
            end
            in_valid = 1'b0;
        endtask

        task automatic send_rand();
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        endtask

        task automatic wait_drain();
            int t = 0;
            while (exp_q.size() != 0 && t < 400) begin
                @(posedge clk);
                t++;
            end
            #1;
            chk({tag, "_drain_left"}, 64'(exp_q.size()), 64'(0));
        endtask

        // Asynchronous reset mid-cycle; outputs must clear at once.
        task automatic apply_reset();
            #1;
            rst_n = 1'b0;
            exp_q.delete();
            #1;
            chk({tag, "_rst_out_valid"}, 64'(out_valid), 64'(0));
            chk({tag, "_rst_sum"}, 64'(sum), 64'(0));
            chk({tag, "_rst_flags"}, 64'({c_out, overflow, zero}), 64'(0));
            chk({tag, "_rst_in_ready"}, 64'(in_ready), 64'(1));
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        endtask

        initial begin
            int edges, t0, stale;
            tag      = $sformatf("cfg%0d_w%0d_s%0d", g, W, S);
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
            c_in     = 1'b0;
            sub      = 1'b0;
            apply_reset();

            // Latency on an empty pipe; also the inter-chunk carry case.
            @(posedge clk);
            #1;
            send(HALF, W'(1), 1'b0, 1'b0, mk(BIT_H, 1'b0, 1'b0, 1'b0));
            edges = 1;
            while (!out_valid && edges < 20) begin
                @(posedge clk);
                #1;
                edges++;
            end
            chk({tag, "_latency"}, 64'(edges), 64'(S));

            // Directed vectors, hand-computed expectations.
            send(ONES, W'(1), 1'b0, 1'b0, mk('0, 1'b1, 1'b0, 1'b1));
            send(MAXP, W'(1), 1'b0, 1'b0, mk(MINN, 1'b0, 1'b1, 1'b0));
            send(W'(5), W'(7), 1'b0, 1'b1, mk(~W'(1), 1'b0, 1'b0, 1'b0));
            send(W'(7), W'(5), 1'b0, 1'b1, mk(W'(2), 1'b1, 1'b0, 1'b0));
            send(MINN, W'(1), 1'b0, 1'b1, mk(MAXP, 1'b1, 1'b1, 1'b0));
            send(W'(7), W'(5), 1'b1, 1'b1, mk(W'(1), 1'b1, 1'b0, 1'b0));
            send(ONES, ONES, 1'b1, 1'b0, mk(ONES, 1'b1, 1'b0, 1'b0));
            send('0, '0, 1'b0, 1'b1, mk('0, 1'b1, 1'b0, 1'b1));
            send('0, W'(1), 1'b0, 1'b1, mk(ONES, 1'b0, 1'b0, 1'b0));
            wait_drain();

            // Back-to-back stream: every op must be accepted on consecutive edges.
            @(posedge clk);
            #1;
            t0 = cyc;
            for (int i = 0; i < 100; i++) send_rand();
            chk({tag, "_stream_cycles"}, 64'(cyc - t0), 64'(100));
            wait_drain();

            // Random producer gaps and random consumer stalls.
            rand_or = 1'b1;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_rand();
            end
            wait_drain();
            rand_or  = 1'b0;
            or_force = 1'b1;

            // Fill with consumer blocked, hold, then drain.
            @(posedge clk);
            #1;
            or_force = 1'b0;
            for (int i = 0; i < S; i++) send_rand();
            chk({tag, "_full_in_ready"}, 64'(in_ready), 64'(0));
            chk({tag, "_full_out_valid"}, 64'(out_valid), 64'(1));
            repeat (5) @(posedge clk);
            #1;
            chk({tag, "_held_in_ready"}, 64'(in_ready), 64'(0));
            or_force = 1'b1;
            wait_drain();

            // Reset with two ops in flight; nothing may come out afterwards.
            @(posedge clk);
            #1;
            send_rand();
            send_rand();
            apply_reset();
            stale = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (out_valid) stale++;
            end
            chk({tag, "_stale_after_reset"}, 64'(stale), 64'(0));

            // Recovery after reset.
            send(W'(7), W'(5), 1'b0, 1'b1, mk(W'(2), 1'b1, 1'b0, 1'b0));
            wait_drain();
            done[g] = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(done[0] && done[1] && done[2]) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("all_configs_done", 64'({done[0], done[1], done[2]}), 64'(3'b111));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
